// File: rtl/pio_step_gen_pkg.sv
// Shared types and helpers for the PIO-driven step/direction pulse generator.
// The command byte layout and period arithmetic live here so all users agree on them.
package pio_step_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDsetup,
    StHigh,
    StLow
  } step_state_t;

  localparam int unsigned CMD_DIR_BIT = 7;
  localparam int unsigned CMD_SPD_MSB = 6;

  // Step period in clock cycles; speed 0 is never passed in (it means stop).
  function automatic int unsigned step_period(input int unsigned base_div,
                                              input logic [6:0]  speed);
    return base_div * (32'd128 - 32'(speed));
  endfunction

endpackage

// File: rtl/pio_step_gen.sv
// Step/direction generator: turns the PIO command byte into STEP/DIR waveforms
// and tracks a signed step position. One FSM, one shared down-counter.
module pio_step_gen
  import pio_step_gen_pkg::*;
#(
  parameter int unsigned BASE_DIV  = 500,
  parameter int unsigned PULSE_W   = 100,
  parameter int unsigned DIR_SETUP = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  cmd,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic [31:0] position
);

  localparam int unsigned PER_W = $clog2(BASE_DIV * 128);
  localparam int unsigned DS_W  = $clog2(DIR_SETUP + 1);
  localparam int unsigned CNT_W = (PER_W > DS_W) ? PER_W : DS_W;

  if (BASE_DIV <= PULSE_W) begin : g_bad_div
    $error("pio_step_gen: BASE_DIV must be greater than PULSE_W");
  end
  if (DIR_SETUP < 1) begin : g_bad_setup
    $error("pio_step_gen: DIR_SETUP must be at least 1");
  end

  step_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic [31:0]        position_q, position_d;

  logic               cmd_dir;
  logic [6:0]         cmd_spd;
  logic [PER_W-1:0]   cmd_per;
  logic               decide;
  logic               go_high;

  assign cmd_dir = cmd[CMD_DIR_BIT];
  assign cmd_spd = cmd[CMD_SPD_MSB:0];
  assign cmd_per = PER_W'(step_period(BASE_DIV, cmd_spd));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    step_d     = step_q;
    dir_d      = dir_q;
    position_d = position_q;
    decide     = 1'b0;
    go_high    = 1'b0;

    unique case (state_q)
      StIdle: begin
        decide = 1'b1;
      end
      StDsetup: begin
        if (cnt_q == '0) begin
          go_high = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHigh: begin
        if (cnt_q == '0) begin
          state_d = StLow;
          step_d  = 1'b0;
          cnt_d   = CNT_W'(per_q) - CNT_W'(PULSE_W + 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLow: begin
        if (cnt_q == '0) begin
          decide = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase

    // The period is captured at the decision point so a stop or speed change
    // during direction setup cannot alter the step that is already committed.
    if (decide) begin
      if (cmd_spd == '0) begin
        state_d = StIdle;
      end else begin
        per_d = cmd_per;
        if (cmd_dir != dir_q) begin
          dir_d   = cmd_dir;
          state_d = StDsetup;
          cnt_d   = CNT_W'(DIR_SETUP - 1);
        end else begin
          go_high = 1'b1;
        end
      end
    end

    if (go_high) begin
      state_d    = StHigh;
      step_d     = 1'b1;
      cnt_d      = CNT_W'(PULSE_W - 1);
      position_d = dir_q ? (position_q - 32'd1) : (position_q + 32'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      per_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      position_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      position_q <= position_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign busy     = (state_q != StIdle);
  assign position = position_q;

endmodule
